pc_fetch_ctrl: RTL

Parametrised program-counter and fetch-request controller for the RV32I core. It sits between the EX-stage redirect sources (trap, mret, sret, jump) and the instruction-memory port. It adds a valid/ack fetch handshake, a bounded number of outstanding fetches, vectored trap entry, and discard tracking for stale fetch responses after any redirect.

---
 rtl/pc_fetch_if.sv | 20 ++
 rtl/pc_fetch_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Fetch request/response handshake between the PC controller and instruction memory.
interface pc_fetch_if #(
    parameter int XLEN = 32
);
    logic            fetch_req;
    logic [XLEN-3:0] fetch_pc;
    logic            fetch_ack;
    logic            fetch_rsp_valid;
    logic            fetch_rsp_keep;

    modport master (
        output fetch_req, fetch_pc, fetch_rsp_keep,
        input  fetch_ack, fetch_rsp_valid
    );

    modport slave (
        input  fetch_req, fetch_pc, fetch_rsp_keep,
        output fetch_ack, fetch_rsp_valid
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-request controller: redirects, bounded outstanding
// fetches, vectored trap entry and discard tracking for stale fetch responses.
module pc_fetch_ctrl #(
    parameter int XLEN      = 32,
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_start,
    input  logic [XLEN-3:0]  cpu_start_adr,
    input  logic             run_en,
    input  logic             trap_take,
    input  logic             trap_is_intr,
    input  logic [4:0]       trap_cause,
    input  logic             cmd_mret_ex,
    input  logic             cmd_sret_ex,
    input  logic             jmp_condition_ex,
    input  logic [XLEN-1:0]  csr_mtvec_ex,
    input  logic [XLEN-3:0]  csr_mepc_ex,
    input  logic [XLEN-3:0]  csr_sepc_ex,
    input  logic [XLEN-3:0]  jmp_adr_ex,
    pc_fetch_if.master       fetch,
    output logic [XLEN-3:0]  pc,
    output logic [CNT_W-1:0] outst_cnt
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    state_t           state, state_next;
    logic [CNT_W-1:0] kill_cnt, outst_next, kill_next;
    logic [XLEN-3:0]  pc_next, trap_target;
    logic             req, accept, rsp_counted, redirect, trap_vectored;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cpu_start) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        req = 1'b0;
        if (state == RUN) req = run_en && (outst_cnt < CNT_MAX);
    end

    // Vectored mode offsets the base by one word per interrupt cause.
    assign trap_vectored = (csr_mtvec_ex[1:0] == 2'b01) && trap_is_intr;
    assign trap_target   = csr_mtvec_ex[XLEN-1:2]
                         + (trap_vectored ? (XLEN-2)'(trap_cause) : '0);

    assign accept      = req && fetch.fetch_ack;
    assign rsp_counted = fetch.fetch_rsp_valid && (outst_cnt != '0);
    assign redirect    = cpu_start || trap_take || cmd_mret_ex
                      || cmd_sret_ex || jmp_condition_ex;
    assign outst_next  = outst_cnt + CNT_W'(accept) - CNT_W'(rsp_counted);

    always_comb begin
        pc_next = pc;
        if (cpu_start)             pc_next = cpu_start_adr;
        else if (trap_take)        pc_next = trap_target;
        else if (cmd_mret_ex)      pc_next = csr_mepc_ex;
        else if (cmd_sret_ex)      pc_next = csr_sepc_ex;
        else if (jmp_condition_ex) pc_next = jmp_adr_ex;
        else if (accept)           pc_next = pc + 1'b1;
    end

    // Everything still in flight after a redirect, including a fetch accepted
    // in the redirect cycle itself, belongs to the old stream.
    always_comb begin
        kill_next = kill_cnt;
        if (redirect)
            kill_next = outst_next;
        else if (fetch.fetch_rsp_valid && (kill_cnt != '0))
            kill_next = kill_cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            outst_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            pc        <= pc_next;
            outst_cnt <= outst_next;
            kill_cnt  <= kill_next;
        end
    end

    assign fetch.fetch_req      = req;
    assign fetch.fetch_pc       = pc;
    assign fetch.fetch_rsp_keep = fetch.fetch_rsp_valid && (kill_cnt == '0);
endmodule
